// File: rtl/key_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioning block.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchronizer, debounce FSM with shared counter, auto-repeat timer.
// Latency: accepted press/release reported DB_CYCLES+2 edges after the first clean sample.
// Backpressure: none; pulses are single-cycle and must be consumed when emitted.
module debounce_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned REPEAT_CYCLES = 1,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES);

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rep_lim;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rep_phase_q, rep_phase_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             key_s;

    assign key_s   = ~sync2_q;
    assign cnt_inc = cnt_q + CNT_W'(1);
    // First repeat waits the long hold time, later ones use the short period.
    assign rep_lim = rep_phase_q ? REP_LIM : HOLD_LIM;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rep_phase_d = rep_phase_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LIM) begin
                    state_d     = HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    cnt_d       = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (REPEAT_EN) begin
                    if (cnt_inc == rep_lim) begin
                        repeat_d    = 1'b1;
                        cnt_d       = '0;
                        rep_phase_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                // A release glitch restarts the full hold time so it cannot fire a repeat early.
                if (key_s) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    rep_phase_d = 1'b0;
                end else if (cnt_q == DB_LIM) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rep_phase_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_phase_q <= rep_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low buttons into clean levels plus press/release/repeat pulses.
// Latency: DEBOUNCE_MS worth of cycles + 2 from a clean key edge to the registered outputs.
// Backpressure: none; channels run independently every cycle.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned N_KEYS      = 2,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 200,
    parameter bit          REPEAT_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int unsigned DB_CYCLES     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned HOLD_CYCLES   = ms_to_cycles(CLK_HZ, HOLD_MS);
    localparam int unsigned REPEAT_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int unsigned CNT_W =
        $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    if (DB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
        $error("key_conditioner: derived cycle counts must all be at least 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_n         (key_n[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner at CLK_HZ=1000 (DB=4, HOLD=10, REPEAT=5), with a no-repeat twin.
module tb_key_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic [1:0] key_level, press_pulse, release_pulse, repeat_pulse;
    logic [1:0] nr_level, nr_press, nr_release, nr_repeat;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS(2), .CLK_HZ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10), .REPEAT_MS(5), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_n(key_n),
        .key_level(key_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    key_conditioner #(
        .N_KEYS(2), .CLK_HZ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10), .REPEAT_MS(5), .REPEAT_EN(1'b0)
    ) dut_nr (
        .clk(clk), .reset_n(reset_n), .key_n(key_n),
        .key_level(nr_level), .press_pulse(nr_press),
        .release_pulse(nr_release), .repeat_pulse(nr_repeat)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a key is accepted once the synchronized input has held one
    // value for DB+1 consecutive samples; repeats are timed from the moment the
    // key was last seen steadily held.
    typedef struct {
        bit d1, d2;
        bit lvl;
        bit run_v;
        int run_n;
        int hold_start;
        bit press, rel, rep;
    } ch_model_t;

    ch_model_t mdl [2];
    int cyc = 0;

    function automatic ch_model_t model_step(ch_model_t m, bit kn, bit rst_n, int now);
        ch_model_t r;
        bit s;
        int k;
        r = m;
        r.press = 1'b0; r.rel = 1'b0; r.rep = 1'b0;
        if (!rst_n) begin
            r.d1 = 1'b1; r.d2 = 1'b1; r.lvl = 1'b0;
            r.run_v = 1'b0; r.run_n = 0; r.hold_start = 0;
            return r;
        end
        s = ~m.d2;
        r.d2 = m.d1;
        r.d1 = kn;
        if (s == m.run_v) r.run_n = m.run_n + 1;
        else begin r.run_v = s; r.run_n = 1; end
        if (!m.lvl) begin
            if (s && r.run_n == DB + 1) begin r.lvl = 1'b1; r.press = 1'b1; r.hold_start = now; end
        end else if (!s) begin
            if (r.run_n == DB + 1) begin r.lvl = 1'b0; r.rel = 1'b1; end
        end else if (r.run_n == 1) begin
            r.hold_start = now;
        end else begin
            k = now - m.hold_start;
            r.rep = (k >= HOLD) && ((k - HOLD) % REP == 0);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) mdl[i] <= model_step(mdl[i], key_n[i], reset_n, cyc);
        cyc <= cyc + 1;
    end

    function automatic logic [7:0] exp_vec(input bit norep);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 2; i++) begin
            v[6+i] = mdl[i].lvl;
            v[4+i] = mdl[i].press;
            v[2+i] = mdl[i].rel;
            v[i]   = norep ? 1'b0 : mdl[i].rep;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_main", {key_level, press_pulse, release_pulse, repeat_pulse}, exp_vec(1'b0));
            check("model_norep", {nr_level, nr_press, nr_release, nr_repeat}, exp_vec(1'b1));
        end
    end

    // Sequence player: seq[k] is sampled at relative edge k, outputs of that edge land in ob_*[k].
    logic [1:0] seq   [0:127];
    logic [1:0] ob_l  [0:127];
    logic [1:0] ob_p  [0:127];
    logic [1:0] ob_r  [0:127];
    logic [1:0] ob_x  [0:127];
    logic [1:0] ob_nx [0:127];

    task automatic run_seq(input int n);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            key_n = seq[k];
            @(posedge clk); #1;
            ob_l[k]  = key_level;
            ob_p[k]  = press_pulse;
            ob_r[k]  = release_pulse;
            ob_x[k]  = repeat_pulse;
            ob_nx[k] = nr_repeat;
        end
    endtask

    int n_p, e_p, n_r, e_r, n_x, e_x, n_nx, n_lo;

    task automatic tally(input int n, input int ch, input int from, input int lo_a, input int lo_b);
        n_p = 0; e_p = -1; n_r = 0; e_r = -1; n_x = 0; e_x = -1; n_nx = 0; n_lo = 0;
        for (int k = 0; k < n; k++) begin
            if (ob_p[k][ch]) begin n_p++; if (e_p < 0) e_p = k; end
            if (ob_r[k][ch]) begin n_r++; if (e_r < 0) e_r = k; end
            if (ob_x[k][ch]) begin n_x++; if (e_x < 0 && k >= from) e_x = k; end
            if (ob_nx[k][ch]) n_nx++;
            if (k >= lo_a && k <= lo_b && !ob_l[k][ch]) n_lo++;
        end
    endtask

    typedef struct {
        int low_len;
        int n_press;
        int press_edge;
        int n_rel;
        int rel_edge;
        int n_rep;
        int rep_edge;
    } vec_t;

    vec_t vt [7];
    int   dur [2];

    initial begin
        vt[0] = '{1,  0, -1, 0, -1, 0, -1};
        vt[1] = '{3,  0, -1, 0, -1, 0, -1};
        vt[2] = '{4,  0, -1, 0, -1, 0, -1};
        vt[3] = '{5,  1,  6, 1, 11, 0, -1};
        vt[4] = '{8,  1,  6, 1, 14, 0, -1};
        vt[5] = '{20, 1,  6, 1, 26, 2, 16};
        vt[6] = '{40, 1,  6, 1, 46, 6, 16};

        // Reset with both keys already down, then both presses land together at edge 6.
        reset_n = 1'b0;
        key_n   = 2'b00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {key_level, press_pulse, release_pulse, repeat_pulse}, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("reset_press_edge", press_pulse, (k == 6) ? 3 : 0);
        end
        key_n = 2'b11;
        repeat (20) @(posedge clk);
        #1;
        check("reset_released", key_level, 0);

        // Press-length table on key 0.
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 128; k++) seq[k] = (k < vt[t].low_len) ? 2'b10 : 2'b11;
            run_seq(vt[t].low_len + 26);
            tally(vt[t].low_len + 26, 0, 0,
                  (vt[t].n_press != 0) ? vt[t].press_edge : 0,
                  (vt[t].n_press != 0) ? vt[t].rel_edge - 1 : -1);
            check("tbl_npress",  n_p,  vt[t].n_press);
            check("tbl_press_e", e_p,  vt[t].press_edge);
            check("tbl_nrel",    n_r,  vt[t].n_rel);
            check("tbl_rel_e",   e_r,  vt[t].rel_edge);
            check("tbl_nrep",    n_x,  vt[t].n_rep);
            check("tbl_rep_e",   e_x,  vt[t].rep_edge);
            check("tbl_norep",   n_nx, 0);
            check("tbl_level",   n_lo, 0);
        end

        // Bounce: toggle every 2 samples for 12 samples, then hold until sample 40.
        for (int k = 0; k < 128; k++)
            seq[k] = {1'b1, (k < 12) ? 1'(((k / 2) % 2) == 1) : 1'(k >= 40)};
        run_seq(70);
        tally(70, 0, 0, 18, 45);
        check("bounce_npress",  n_p, 1);
        check("bounce_press_e", e_p, 18);
        check("bounce_rel_e",   e_r, 46);
        check("bounce_rep_e",   e_x, 28);
        check("bounce_nrep",    n_x, 3);
        check("bounce_level",   n_lo, 0);

        // Release glitch of 2 samples while held.
        for (int k = 0; k < 128; k++)
            seq[k] = {1'b1, 1'((k == 30) || (k == 31) || (k >= 60))};
        run_seq(80);
        tally(80, 0, 32, 6, 65);
        check("glitch_nrel",    n_r, 1);
        check("glitch_rel_e",   e_r, 66);
        check("glitch_next_rep", e_x, 44);
        check("glitch_level",   n_lo, 0);

        // Simultaneous presses on both keys.
        for (int k = 0; k < 128; k++) seq[k] = (k < 20) ? 2'b00 : 2'b11;
        run_seq(40);
        check("simul_both", ob_p[6], 3);
        tally(40, 1, 0, 6, 25);
        check("simul_k1_press_e", e_p, 6);
        check("simul_k1_rel_e",   e_r, 26);

        // Reset while both keys are held.
        for (int k = 0; k < 128; k++) seq[k] = 2'b00;
        run_seq(10);
        check("midrst_held", ob_l[9], 3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outputs", {key_level, press_pulse, release_pulse, repeat_pulse}, 0);
        reset_n = 1'b1;
        key_n   = 2'b11;
        for (int k = 0; k < 128; k++) seq[k] = 2'b11;
        run_seq(20);
        tally(20, 0, 0, 0, -1);
        check("midrst_k0_norel", n_r + n_p, 0);
        tally(20, 1, 0, 0, -1);
        check("midrst_k1_norel", n_r + n_p, 0);

        // Random key activity with occasional resets, checked by the model every cycle.
        dur[0] = 0;
        dur[1] = 3;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (dur[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    dur[i] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(6, 1))
                                                         : int'($urandom_range(45, 5));
                end else begin
                    dur[i]--;
                end
            end
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(499, 0) == 0) reset_n = 1'b0;
        end
        reset_n = 1'b1;
        key_n   = 2'b11;
        repeat (20) @(posedge clk);
        #1;
        check("final_idle", {key_level, press_pulse, release_pulse, repeat_pulse}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
